// File: rtl/ir_sensor_emulator_pkg.sv
// rtl/ir_sensor_emulator_pkg.sv - shared count width, defaults and FSM encoding for the IR sensor emulator
package ir_sensor_pkg;

    localparam int CNT_W             = 20;
    localparam int MIN_CHARGE_DEF    = 2048;
    localparam int DEFAULT_DECAY_DEF = 500;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHARGE = 2'd1,
        ST_DECAY  = 2'd2
    } state_t;

endpackage

// File: rtl/ir_sensor_emulator_if.sv
// rtl/ir_sensor_emulator_if.sv - reader-side signal bundle of the IR sensor emulator
interface ir_sensor_emulator_if;
    import ir_sensor_pkg::*;

    logic       enable;
    logic       chargeIn;
    cnt_t       decayTime;
    logic       decayLoad;
    logic       clearErr;
    logic       senseOut;
    logic       busy;
    logic       shortCharge;
    logic [7:0] responseCount;

    modport master (
        output enable, chargeIn, decayTime, decayLoad, clearErr,
        input  senseOut, busy, shortCharge, responseCount
    );

    modport slave (
        input  enable, chargeIn, decayTime, decayLoad, clearErr,
        output senseOut, busy, shortCharge, responseCount
    );

endinterface

// File: rtl/ir_sensor_emulator.sv
// rtl/ir_sensor_emulator.sv - emulates an IR sensor node: charge by the reader, then a timed decay back to low
module ir_sensor_emulator
    import ir_sensor_pkg::*;
#(
    parameter int MIN_CHARGE    = MIN_CHARGE_DEF,
    parameter int DEFAULT_DECAY = DEFAULT_DECAY_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    ir_sensor_emulator_if.slave  bus
);

    localparam cnt_t MIN_CNT = cnt_t'(MIN_CHARGE);
    localparam cnt_t DEF_CNT = cnt_t'(DEFAULT_DECAY);

    state_t     state, state_n;
    cnt_t       charge_cnt, charge_cnt_n;
    cnt_t       decay_cnt, decay_cnt_n;
    cnt_t       decay_reg, decay_reg_n;
    cnt_t       active_decay, active_decay_n;
    logic       sense_q, sense_n;
    logic       busy_q, busy_n;
    logic       short_q, short_n;
    logic [7:0] count_q, count_n;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            charge_cnt   <= '0;
            decay_cnt    <= '0;
            decay_reg    <= DEF_CNT;
            active_decay <= DEF_CNT;
            sense_q      <= 1'b0;
            busy_q       <= 1'b0;
            short_q      <= 1'b0;
            count_q      <= '0;
        end else begin
            state        <= state_n;
            charge_cnt   <= charge_cnt_n;
            decay_cnt    <= decay_cnt_n;
            decay_reg    <= decay_reg_n;
            active_decay <= active_decay_n;
            sense_q      <= sense_n;
            busy_q       <= busy_n;
            short_q      <= short_n;
            count_q      <= count_n;
        end
    end

    always_comb begin
        state_n        = state;
        charge_cnt_n   = charge_cnt;
        decay_cnt_n    = decay_cnt;
        active_decay_n = active_decay;
        decay_reg_n    = bus.decayLoad ? bus.decayTime : decay_reg;
        sense_n        = 1'b0;
        short_n        = short_q & ~bus.clearErr;
        count_n        = count_q;

        if (bus.enable) begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.chargeIn) begin
                        state_n      = ST_CHARGE;
                        charge_cnt_n = cnt_t'(1);
                        sense_n      = 1'b1;
                    end
                end
                ST_CHARGE: begin
                    if (bus.chargeIn) begin
                        sense_n = 1'b1;
                        if (charge_cnt < MIN_CNT)
                            charge_cnt_n = charge_cnt + cnt_t'(1);
                    end else if (charge_cnt >= MIN_CNT) begin
                        state_n        = ST_DECAY;
                        decay_cnt_n    = '0;
                        active_decay_n = decay_reg;
                        sense_n        = 1'b1;
                    end else begin
                        // Released too early: flag it, no decay and no response.
                        state_n = ST_IDLE;
                        short_n = 1'b1;
                    end
                end
                ST_DECAY: begin
                    if (bus.chargeIn) begin
                        state_n      = ST_CHARGE;
                        charge_cnt_n = cnt_t'(1);
                        sense_n      = 1'b1;
                    end else if (decay_cnt == active_decay) begin
                        state_n = ST_IDLE;
                        count_n = count_q + 8'd1;
                    end else begin
                        decay_cnt_n = decay_cnt + cnt_t'(1);
                        sense_n     = 1'b1;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end else begin
            state_n = ST_IDLE;
        end

        busy_n = (state_n != ST_IDLE);
    end

    assign bus.senseOut      = sense_q;
    assign bus.busy          = busy_q;
    assign bus.shortCharge   = short_q;
    assign bus.responseCount = count_q;

endmodule

// File: tb/tb_ir_sensor_emulator.sv
// tb/tb_ir_sensor_emulator.sv - self-checking bench for ir_sensor_emulator
module tb_ir_sensor_emulator;
    import ir_sensor_pkg::*;

    localparam int MINC = 128;
    localparam int DEFD = 500;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    ir_sensor_emulator_if bus();

    ir_sensor_emulator #(.MIN_CHARGE(MINC), .DEFAULT_DECAY(DEFD)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 idle, 1 charging, 2 decaying; decay tracked as clocks left.
    int m_phase, m_charged, m_left, m_pending, m_active, m_count;
    bit m_sense, m_short;

    typedef struct {
        bit en; bit ci; bit ld; int dt; bit clr; int n;
        bit s;  bit b;  bit sh; int cnt;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int next_pending;
        bit set_short;
        if (reset) begin
            m_phase = 0; m_charged = 0; m_left = 0;
            m_pending = DEFD; m_active = DEFD;
            m_sense = 0; m_short = 0; m_count = 0;
            return;
        end
        next_pending = bus.decayLoad ? int'(bus.decayTime) : m_pending;
        set_short = 0;
        m_sense = 0;
        if (!bus.enable) begin
            m_phase = 0;
        end else if (m_phase == 0) begin
            if (bus.chargeIn) begin m_phase = 1; m_charged = 1; m_sense = 1; end
        end else if (m_phase == 1) begin
            if (bus.chargeIn) begin
                m_charged++; m_sense = 1;
            end else if (m_charged >= MINC) begin
                m_phase = 2; m_active = m_pending; m_left = m_active; m_sense = 1;
            end else begin
                m_phase = 0; set_short = 1;
            end
        end else begin
            if (bus.chargeIn) begin
                m_phase = 1; m_charged = 1; m_sense = 1;
            end else if (m_left == 0) begin
                m_phase = 0; m_count = (m_count + 1) % 256;
            end else begin
                m_left--; m_sense = 1;
            end
        end
        m_short   = set_short | (m_short & !bus.clearErr);
        m_pending = next_pending;
    endtask

    task automatic cycle();
        logic [10:0] exp;
        model_step();
        @(posedge clock);
        #1;
        exp = {m_sense, m_phase != 0, m_short, m_count[7:0]};
        check("model {sense,busy,short,count}",
              {21'd0, bus.senseOut, bus.busy, bus.shortCharge, bus.responseCount}, {21'd0, exp});
    endtask

    task automatic drive(input bit en, input bit ci, input bit ld, input int dt, input bit clr);
        bus.enable    = en;
        bus.chargeIn  = ci;
        bus.decayLoad = ld;
        bus.decayTime = cnt_t'(dt);
        bus.clearErr  = clr;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1, 0, 0, 0, 0);
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic charge_release(input int n);
        drive(1, 1, 0, 0, 0);
        repeat (n) cycle();
        drive(1, 0, 0, 0, 0);
        cycle();
    endtask

    initial begin
        int n, run_left;
        bit held;

        do_reset();
        check("reset sense", bus.senseOut, 0);
        check("reset busy", bus.busy, 0);
        check("reset short", bus.shortCharge, 0);
        check("reset count", bus.responseCount, 0);

        tbl.push_back('{1,0,0,0,0,   3, 0,0,0,0});
        tbl.push_back('{1,1,0,0,0, 128, 1,1,0,0});
        tbl.push_back('{1,0,0,0,0, 501, 1,1,0,0});
        tbl.push_back('{1,0,0,0,0,   1, 0,0,0,1});
        tbl.push_back('{1,1,0,0,0, 100, 1,1,0,1});
        tbl.push_back('{1,0,0,0,0,   1, 0,0,1,1});
        tbl.push_back('{1,0,0,0,1,   1, 0,0,0,1});
        tbl.push_back('{1,1,0,0,0, 127, 1,1,0,1});
        tbl.push_back('{1,0,0,0,0,   1, 0,0,1,1});
        tbl.push_back('{1,1,0,0,1, 128, 1,1,0,1});
        tbl.push_back('{1,0,0,0,0,   1, 1,1,0,1});
        tbl.push_back('{0,0,0,0,0,   1, 0,0,0,1});
        tbl.push_back('{1,0,1,0,0,   1, 0,0,0,1});
        tbl.push_back('{1,1,0,0,0, 128, 1,1,0,1});
        tbl.push_back('{1,0,0,0,0,   1, 1,1,0,1});
        tbl.push_back('{1,0,0,0,0,   1, 0,0,0,2});
        tbl.push_back('{1,1,0,0,0,  50, 1,1,0,2});
        tbl.push_back('{1,0,0,0,1,   1, 0,0,1,2});
        tbl.push_back('{1,0,0,0,1,   1, 0,0,0,2});
        tbl.push_back('{1,0,1,3000,0,1, 0,0,0,2});

        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].ci, tbl[i].ld, tbl[i].dt, tbl[i].clr);
            repeat (tbl[i].n) cycle();
            check($sformatf("vec%0d sense", i), bus.senseOut, tbl[i].s);
            check($sformatf("vec%0d busy", i), bus.busy, tbl[i].b);
            check($sformatf("vec%0d short", i), bus.shortCharge, tbl[i].sh);
            check($sformatf("vec%0d count", i), bus.responseCount, tbl[i].cnt);
        end

        // Reader recharges part-way through a long decay.
        charge_release(MINC);
        held = 1;
        repeat (2000) begin
            cycle();
            if (!bus.senseOut) held = 0;
        end
        check("abort sense held", held, 1);
        drive(1, 1, 0, 0, 0);
        cycle();
        check("abort sense", bus.senseOut, 1);
        check("abort busy", bus.busy, 1);
        check("abort count", bus.responseCount, 2);
        drive(0, 0, 0, 0, 0);
        cycle();
        check("disable idle", bus.busy, 0);

        // Load issued mid-decay applies only to the following decay.
        drive(1, 0, 1, DEFD, 0);
        cycle();
        charge_release(MINC);
        n = 0;
        while (bus.senseOut && n < 4000) begin
            n++;
            drive(1, 0, n == 200, 10, 0);
            cycle();
        end
        check("decay length with mid load", n, DEFD + 1);
        charge_release(MINC);
        n = 0;
        while (bus.senseOut && n < 4000) begin
            n++;
            drive(1, 0, 0, 0, 0);
            cycle();
        end
        check("decay length after load", n, 11);

        // Response counter wraps after 256 completed decays.
        do_reset();
        drive(1, 0, 1, 0, 0);
        cycle();
        for (int k = 1; k <= 256; k++) begin
            charge_release(MINC);
            cycle();
            if (k == 255) check("count 255", bus.responseCount, 255);
        end
        check("count wrap", bus.responseCount, 0);

        // Reset in the middle of a decay.
        drive(1, 0, 1, DEFD, 0);
        cycle();
        charge_release(MINC);
        repeat (5) cycle();
        check("mid decay sense", bus.senseOut, 1);
        reset = 1'b1;
        cycle();
        check("reset mid decay sense", bus.senseOut, 0);
        check("reset mid decay busy", bus.busy, 0);
        check("reset mid decay count", bus.responseCount, 0);
        reset = 1'b0;

        // Randomised traffic against the model.
        run_left = 0;
        bus.chargeIn = 0;
        for (int c = 0; c < 8000; c++) begin
            if (run_left == 0) begin
                bus.chargeIn = ~bus.chargeIn;
                run_left = bus.chargeIn ? int'($urandom_range(90, 170)) : int'($urandom_range(1, 80));
            end
            run_left--;
            bus.enable    = ($urandom_range(0, 99) != 0);
            bus.decayLoad = ($urandom_range(0, 49) == 0);
            bus.decayTime = cnt_t'($urandom_range(0, 200));
            bus.clearErr  = ($urandom_range(0, 39) == 0);
            reset         = ($urandom_range(0, 1999) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
